// File: rtl/sseg_scan_capture_pkg.sv
// Shared constants for the seven-segment scan capture slice: glyph patterns,
// the "no digit" BCD code, FSM encoding and the decoded-glyph record.
package sseg_scan_capture_pkg;

  // Active-low gfedcba patterns
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_NONE = 4'hF;

  localparam logic [1:0] ST_WAIT_AN = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  typedef struct packed {
    logic       err;
    logic [3:0] bcd;
  } glyph_dec_t;

  // Exactly one active-low anode asserted
  function automatic logic an_legal(input logic [3:0] an_val);
    return ($countones(~an_val) == 1);
  endfunction

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational inverse of the BCD-to-segment decoder: 7-bit active-low
// glyph to BCD digit, with an error flag for patterns that are neither a digit nor blank.
module sseg_glyph_decode
  import sseg_scan_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output glyph_dec_t dec
);

  always_comb begin
    dec = '{err: 1'b1, bcd: BCD_NONE};
    case (pattern)
      GLYPH_0:     dec = '{err: 1'b0, bcd: 4'd0};
      GLYPH_1:     dec = '{err: 1'b0, bcd: 4'd1};
      GLYPH_2:     dec = '{err: 1'b0, bcd: 4'd2};
      GLYPH_3:     dec = '{err: 1'b0, bcd: 4'd3};
      GLYPH_4:     dec = '{err: 1'b0, bcd: 4'd4};
      GLYPH_5:     dec = '{err: 1'b0, bcd: 4'd5};
      GLYPH_6:     dec = '{err: 1'b0, bcd: 4'd6};
      GLYPH_7:     dec = '{err: 1'b0, bcd: 4'd7};
      GLYPH_8:     dec = '{err: 1'b0, bcd: 4'd8};
      GLYPH_9:     dec = '{err: 1'b0, bcd: 4'd9};
      GLYPH_BLANK: dec = '{err: 1'b0, bcd: BCD_NONE};
      default:     dec = '{err: 1'b1, bcd: BCD_NONE};
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Receive side of a multiplexed an/sseg display bus: samples each digit once
// stable, decodes it, and publishes complete 4-digit frames atomically.
module sseg_scan_capture
  import sseg_scan_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int TMO_W         = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] bcd_0,
  output logic [3:0] bcd_1,
  output logic [3:0] bcd_2,
  output logic [3:0] bcd_3,
  output logic [3:0] dp,
  output logic [3:0] glyph_err,
  output logic       frame_valid,
  output logic       stale
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX     = '1;

  logic [3:0]       an_meta_reg, an_sync_reg, an_snap_reg, an_snap_next;
  logic [7:0]       sseg_meta_reg, sseg_sync_reg, sseg_snap_reg, sseg_snap_next;
  logic [1:0]       state_reg, state_next;
  logic [7:0]       count_reg, count_next;
  logic [3:0]       seen_reg, seen_next;
  logic [3:0]       shadow_bcd_reg [4];
  logic [3:0]       shadow_dp_reg, shadow_err_reg;
  logic [3:0]       bcd_reg [4];
  logic [3:0]       dp_reg, err_reg;
  logic             frame_valid_reg, stale_reg, stale_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             legal, changed, sample, commit;
  glyph_dec_t       snap_dec;

  sseg_glyph_decode u_decode (
    .pattern (sseg_snap_reg[6:0]),
    .dec     (snap_dec)
  );

  assign legal   = an_legal(an_sync_reg);
  assign changed = (an_sync_reg != an_snap_reg) || (sseg_sync_reg != sseg_snap_reg);
  assign commit  = (seen_reg == 4'b1111);

  always_comb begin
    state_next     = state_reg;
    an_snap_next   = an_snap_reg;
    sseg_snap_next = sseg_snap_reg;
    count_next     = count_reg;
    sample         = 1'b0;
    case (state_reg)
      ST_SETTLE: begin
        if (changed) begin
          if (legal) begin
            an_snap_next   = an_sync_reg;
            sseg_snap_next = sseg_sync_reg;
            count_next     = 8'd1;
          end else begin
            state_next = ST_WAIT_AN;
          end
        end else if (count_reg >= SETTLE_LAST) begin
          sample     = 1'b1;
          state_next = ST_HOLD;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      // Segment changes while holding are the driver moving on; only an matters
      ST_HOLD: begin
        if (an_sync_reg != an_snap_reg) begin
          if (legal) begin
            state_next     = ST_SETTLE;
            an_snap_next   = an_sync_reg;
            sseg_snap_next = sseg_sync_reg;
            count_next     = 8'd1;
          end else begin
            state_next = ST_WAIT_AN;
          end
        end
      end
      default: begin
        if (legal) begin
          state_next     = ST_SETTLE;
          an_snap_next   = an_sync_reg;
          sseg_snap_next = sseg_sync_reg;
          count_next     = 8'd1;
        end
      end
    endcase
  end

  // A sample landing in the commit cycle belongs to the next frame
  assign seen_next  = (commit ? 4'b0000 : seen_reg) | (sample ? ~an_snap_reg : 4'b0000);
  assign tmo_next   = commit ? '0 : ((tmo_reg == TMO_MAX) ? tmo_reg : tmo_reg + 1'b1);
  assign stale_next = commit ? 1'b0 : (stale_reg | (tmo_next == TMO_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_meta_reg     <= 4'hF;
      an_sync_reg     <= 4'hF;
      sseg_meta_reg   <= 8'hFF;
      sseg_sync_reg   <= 8'hFF;
      state_reg       <= ST_WAIT_AN;
      an_snap_reg     <= 4'hF;
      sseg_snap_reg   <= 8'hFF;
      count_reg       <= 8'd0;
      seen_reg        <= 4'b0000;
      dp_reg          <= 4'b0000;
      err_reg         <= 4'b0000;
      frame_valid_reg <= 1'b0;
      stale_reg       <= 1'b0;
      tmo_reg         <= '0;
    end else begin
      an_meta_reg     <= an;
      an_sync_reg     <= an_meta_reg;
      sseg_meta_reg   <= sseg;
      sseg_sync_reg   <= sseg_meta_reg;
      state_reg       <= state_next;
      an_snap_reg     <= an_snap_next;
      sseg_snap_reg   <= sseg_snap_next;
      count_reg       <= count_next;
      seen_reg        <= seen_next;
      frame_valid_reg <= commit;
      stale_reg       <= stale_next;
      tmo_reg         <= tmo_next;
      if (commit) begin
        dp_reg  <= shadow_dp_reg;
        err_reg <= shadow_err_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shadow_bcd_reg[gi] <= BCD_NONE;
          shadow_dp_reg[gi]  <= 1'b0;
          shadow_err_reg[gi] <= 1'b0;
          bcd_reg[gi]        <= BCD_NONE;
        end else begin
          if (sample && !an_snap_reg[gi]) begin
            shadow_bcd_reg[gi] <= snap_dec.bcd;
            shadow_dp_reg[gi]  <= ~sseg_snap_reg[7];
            shadow_err_reg[gi] <= snap_dec.err;
          end
          if (commit) begin
            bcd_reg[gi] <= shadow_bcd_reg[gi];
          end
        end
      end
    end
  endgenerate

  assign bcd_0       = bcd_reg[0];
  assign bcd_1       = bcd_reg[1];
  assign bcd_2       = bcd_reg[2];
  assign bcd_3       = bcd_reg[3];
  assign dp          = dp_reg;
  assign glyph_err   = err_reg;
  assign frame_valid = frame_valid_reg;
  assign stale       = stale_reg;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Scoreboard bench for sseg_scan_capture: directed scans push expected frames,
// a monitor pops and compares on every frame_valid pulse.
module tb_sseg_scan_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [3:0] bcd_0, bcd_1, bcd_2, bcd_3, dp, glyph_err;
  logic       frame_valid, stale;

  always #5 clk = ~clk;

  sseg_scan_capture #(.SETTLE_CYCLES(4), .TMO_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .sseg        (sseg),
    .bcd_0       (bcd_0),
    .bcd_1       (bcd_1),
    .bcd_2       (bcd_2),
    .bcd_3       (bcd_3),
    .dp          (dp),
    .glyph_err   (glyph_err),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  // Hand-written active-low {dp,gfedcba}, dp off
  localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0, S4 = 8'h99;
  localparam logic [7:0] S5 = 8'h92, S6 = 8'h82, S7 = 8'hF8, S8 = 8'h80, S9 = 8'h90;
  localparam logic [7:0] SB = 8'hFF;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic [3:0]  err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   nframes = 0;
  logic got;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] b, input logic [3:0] d, input logic [3:0] e);
    exp_q.push_back(exp_t'{bcd: b, dp: d, err: e});
  endtask

  task automatic drive_digit(input int idx, input logic [7:0] s, input int n);
    an   = ~(4'b0001 << idx);
    sseg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
    drive_digit(0, s0, 10);
    drive_digit(1, s1, 10);
    drive_digit(2, s2, 10);
    drive_digit(3, s3, 10);
  endtask

  // Monitor: every frame_valid must match the oldest pending expectation
  always @(posedge clk) begin
    #1;
    if (reset === 1'b1 && frame_valid === 1'b1) begin
      nframes++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: got bcd %h%h%h%h, required no frame", bcd_3, bcd_2, bcd_1, bcd_0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("[TB] frame %0d bcd=%h%h%h%h dp=%b err=%b stale=%b", nframes,
                 bcd_3, bcd_2, bcd_1, bcd_0, dp, glyph_err, stale);
        check("frame_bcd",   {bcd_3, bcd_2, bcd_1, bcd_0}, mon_e.bcd);
        check("frame_dp",    16'(dp), 16'(mon_e.dp));
        check("frame_err",   16'(glyph_err), 16'(mon_e.err));
        check("frame_stale", 16'(stale), 16'h0);
      end
    end
  end

  initial begin
    reset = 1'b0;
    an    = 4'hF;
    sseg  = SB;
    repeat (2) @(negedge clk);
    check("rst_bcd",   {bcd_3, bcd_2, bcd_1, bcd_0}, 16'hFFFF);
    check("rst_dp",    16'(dp), 16'h0);
    check("rst_err",   16'(glyph_err), 16'h0);
    check("rst_valid", 16'(frame_valid), 16'h0);
    check("rst_stale", 16'(stale), 16'h0);
    reset = 1'b1;
    @(negedge clk);

    // Plain scans, one frame per scan
    push_exp(16'h1234, 4'b0000, 4'b0000); drive_frame(S4, S3, S2, S1);
    push_exp(16'h1234, 4'b0000, 4'b0000); drive_frame(S4, S3, S2, S1);
    push_exp(16'h7650, 4'b0101, 4'b0000); drive_frame(8'h40, S5, 8'h02, S7);
    push_exp(16'h9098, 4'b0000, 4'b0000); drive_frame(S8, S9, S0, S9);

    // Segment glitch during settle on digit 1: only the final stable glyph counts
    push_exp(16'h1254, 4'b0000, 4'b0000);
    drive_digit(0, S4, 10);
    drive_digit(1, S8, 2);
    drive_digit(1, S3, 1);
    drive_digit(1, S8, 1);
    drive_digit(1, S5, 10);
    drive_digit(2, S2, 10);
    drive_digit(3, S1, 10);

    // Blank, blank with dp, and a non-glyph on digit 2
    push_exp(16'h1F34, 4'b0000, 4'b0000); drive_frame(S4, S3, SB, S1);
    push_exp(16'h1F34, 4'b0100, 4'b0000); drive_frame(S4, S3, 8'h7F, S1);
    push_exp(16'h1F34, 4'b0000, 4'b0100); drive_frame(S4, S3, 8'b1_0101010, S1);

    // Illegal anodes must never produce a frame
    sseg = S8;
    an = 4'b0000; repeat (10) @(negedge clk);
    an = 4'b1111; repeat (10) @(negedge clk);
    an = 4'b1001; repeat (10) @(negedge clk);
    push_exp(16'h1234, 4'b0000, 4'b0000); drive_frame(S4, S3, S2, S1);

    // Timeout: freeze on digit 3 after a frame
    push_exp(16'h4321, 4'b0000, 4'b0000);
    drive_digit(0, S1, 10);
    drive_digit(1, S2, 10);
    drive_digit(2, S3, 10);
    an   = 4'b0111;
    sseg = S4;
    got  = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (frame_valid === 1'b1) got = 1'b1;
    end
    check("tmo_frame_seen", 16'(got), 16'h1);
    repeat (14) @(posedge clk);
    #1;
    check("tmo_stale_at_14", 16'(stale), 16'h0);
    @(posedge clk); #1;
    check("tmo_stale_at_15", 16'(stale), 16'h1);
    check("tmo_hold_bcd", {bcd_3, bcd_2, bcd_1, bcd_0}, 16'h4321);
    repeat (5) @(posedge clk);
    #1;
    check("tmo_stale_holds", 16'(stale), 16'h1);
    @(negedge clk);
    push_exp(16'h1234, 4'b0000, 4'b0000); drive_frame(S4, S3, S2, S1);

    // Async reset after digits 0,1 sampled
    drive_digit(0, S1, 10);
    drive_digit(1, S2, 10);
    an   = 4'b1011;
    sseg = S3;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_bcd",   {bcd_3, bcd_2, bcd_1, bcd_0}, 16'hFFFF);
    check("arst_dp",    16'(dp), 16'h0);
    check("arst_err",   16'(glyph_err), 16'h0);
    check("arst_valid", 16'(frame_valid), 16'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    drive_digit(1, S3, 10);
    drive_digit(2, S4, 10);
    drive_digit(3, S5, 10);
    push_exp(16'h5436, 4'b0000, 4'b0000);
    drive_digit(0, S6, 10);
    an = 4'hF;
    repeat (10) @(negedge clk);
    check("pending_frames", 16'(exp_q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
